// File: rtl/instr_mem_loader_if.sv
// Byte-stream, control and instruction-memory write bus between a program
// source and the instruction memory loader.
interface instr_mem_loader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [CNT_WIDTH-1:0]  num_words;
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_din;
  logic                  cpu_hold;
  logic                  done;
  logic                  len_err;

  modport master (
    output start, base_addr, num_words, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_din, cpu_hold, done, len_err
  );

  modport slave (
    input  start, base_addr, num_words, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_din, cpu_hold, done, len_err
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Packs a big-endian byte stream into 32-bit words and writes them to
// consecutive instruction memory addresses while holding the CPU stalled.
module instr_mem_loader #(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WORDS  = 1024,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  instr_mem_loader_if.slave     bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_WORDS);

  logic [1:0]            state;
  logic [1:0]            byte_cnt;
  logic [23:0]           shreg;
  logic [CNT_WIDTH-1:0]  words_left;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           din;
  logic                  len_err;
  logic                  over_len;

  assign over_len = (bus.num_words > MAX_CNT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      byte_cnt   <= 2'd0;
      shreg      <= 24'd0;
      words_left <= '0;
      addr       <= '0;
      din        <= 32'd0;
      len_err    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            addr       <= {bus.base_addr[ADDR_WIDTH-1:2], 2'b00};
            words_left <= over_len ? MAX_CNT : bus.num_words;
            len_err    <= over_len;
            byte_cnt   <= 2'd0;
            state      <= (bus.num_words == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (bus.byte_valid) begin
            // Only the low 24 bits are kept; the 4th byte completes the word.
            shreg    <= {shreg[15:0], bus.byte_in};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              din   <= {shreg, bus.byte_in};
              state <= WRITE;
            end
          end
        end
        WRITE: begin
          addr       <= addr + ADDR_WIDTH'(4);
          words_left <= words_left - 1'b1;
          state      <= (words_left == CNT_WIDTH'(1)) ? DONE : LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.byte_ready = (state == LOAD);
  assign bus.cpu_hold   = (state == LOAD) || (state == WRITE);
  assign bus.mem_we     = (state == WRITE);
  assign bus.done       = (state == DONE);
  assign bus.mem_addr   = addr;
  assign bus.mem_din    = din;
  assign bus.len_err    = len_err;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected (address, word) pairs are
// queued as words are streamed and checked against every mem_we pulse.
module tb_instr_mem_loader;
  localparam int AW   = 32;
  localparam int CW   = 16;
  localparam int MAXW = 1024;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  instr_mem_loader_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bif ();

  instr_mem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW), .CNT_WIDTH(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  int checks = 0;
  int errors = 0;
  int writes = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [31:0] exp_addr;

  // Scoreboard consumer: every write strobe must match the oldest queued word.
  always @(negedge clk) begin
    if (reset_n && bif.mem_we === 1'b1) begin
      writes++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected got addr=%h data=%h required no write", bif.mem_addr, bif.mem_din);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bif.mem_addr, bif.mem_din} !== mon_e) begin
          errors++;
          $display("FAIL write_data got addr=%h data=%h required addr=%h data=%h",
                   bif.mem_addr, bif.mem_din, mon_e[63:32], mon_e[31:0]);
        end
      end
    end
  end

  task automatic do_start(input logic [31:0] base, input logic [15:0] n);
    @(negedge clk);
    bif.byte_valid = 1'b0;
    bif.start      = 1'b1;
    bif.base_addr  = base;
    bif.num_words  = n;
    @(negedge clk);
    bif.start = 1'b0;
    exp_addr  = {base[31:2], 2'b00};
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    bit rdy;
    n   = 0;
    rdy = 1'b0;
    @(negedge clk);
    if (gaps) begin
      bif.byte_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    bif.byte_in    = b;
    bif.byte_valid = 1'b1;
    while (!rdy && n < 200) begin
      if (n > 0) @(negedge clk);
      rdy = bif.byte_ready;
      @(posedge clk);
      n++;
    end
    checks++;
    if (!rdy) begin
      errors++;
      $display("FAIL byte_accept got ready=0 for %0d cycles required ready=1", n);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    exp_q.push_back({exp_addr, w});
    exp_addr = exp_addr + 32'd4;
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gaps);
    @(negedge clk);
    checks++;
    if (bif.mem_we !== 1'b1) begin
      errors++;
      $display("FAIL write_latency got mem_we=%b required 1", bif.mem_we);
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (bif.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bif.done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done got done=%b required 1", name, bif.done);
    end
  endtask

  task automatic test_reset();
    bif.start = 1'b0; bif.base_addr = '0; bif.num_words = '0;
    bif.byte_in = 8'h00; bif.byte_valid = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bif.byte_ready, bif.mem_we, bif.cpu_hold, bif.done, bif.len_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b required 00000",
               {bif.byte_ready, bif.mem_we, bif.cpu_hold, bif.done, bif.len_err});
    end
    checks++;
    if (bif.mem_addr !== 32'h0 || bif.mem_din !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus got addr=%h data=%h required 0/0", bif.mem_addr, bif.mem_din);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bif.byte_ready, bif.cpu_hold, bif.done} !== 3'b000) begin
      errors++;
      $display("FAIL idle_outputs got %b required 000", {bif.byte_ready, bif.cpu_hold, bif.done});
    end
  endtask

  task automatic test_basic();
    int w0;
    w0 = writes;
    do_start(32'h0000_0040, 16'd2);
    checks++;
    if ({bif.byte_ready, bif.cpu_hold} !== 2'b11) begin
      errors++;
      $display("FAIL load_outputs got ready/hold=%b required 11", {bif.byte_ready, bif.cpu_hold});
    end
    send_word(32'h2008_0005, 1'b0);
    send_word(32'h0000_000C, 1'b0);
    wait_done("basic");
    checks++;
    if (bif.cpu_hold !== 1'b0 || bif.len_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold got hold=%b len_err=%b required 0/0", bif.cpu_hold, bif.len_err);
    end
    checks++;
    if (bif.mem_addr !== 32'h48 || bif.mem_din !== 32'h0000_000C) begin
      errors++;
      $display("FAIL basic_final got addr=%h data=%h required 00000048/0000000c", bif.mem_addr, bif.mem_din);
    end
    checks++;
    if (writes - w0 !== 2) begin
      errors++;
      $display("FAIL basic_count got %0d writes required 2", writes - w0);
    end
  endtask

  task automatic test_align_wrap();
    do_start(32'h0000_0003, 16'd1);
    send_word(32'hDEAD_BEEF, 1'b0);
    wait_done("align");
    do_start(32'hFFFF_FFFC, 16'd2);
    send_word(32'h1357_9BDF, 1'b0);
    send_word(32'h0246_8ACE, 1'b0);
    wait_done("wrap");
    checks++;
    if (bif.mem_addr !== 32'h0000_0004) begin
      errors++;
      $display("FAIL wrap_addr got %h required 00000004", bif.mem_addr);
    end
  endtask

  task automatic test_zero_words();
    int w0;
    w0 = writes;
    do_start(32'h0000_0100, 16'd0);
    checks++;
    if (bif.done !== 1'b1 || bif.cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL zero_done got done=%b hold=%b required 1/0", bif.done, bif.cpu_hold);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (writes !== w0 || bif.byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_nowrite got writes=%0d ready=%b required 0/0", writes - w0, bif.byte_ready);
    end
  endtask

  task automatic test_over_length();
    int w0;
    w0 = writes;
    do_start(32'h0000_0000, 16'(MAXW + 5));
    checks++;
    if (bif.len_err !== 1'b1) begin
      errors++;
      $display("FAIL len_err_set got %b required 1", bif.len_err);
    end
    for (int i = 0; i < MAXW; i++) send_word($urandom, 1'b0);
    wait_done("overlen");
    checks++;
    if (writes - w0 !== MAXW || bif.mem_addr !== 32'(4 * MAXW)) begin
      errors++;
      $display("FAIL overlen_count got writes=%0d addr=%h required %0d/%h",
               writes - w0, bif.mem_addr, MAXW, 32'(4 * MAXW));
    end
    checks++;
    if (bif.len_err !== 1'b1 || bif.byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL overlen_sticky got len_err=%b ready=%b required 1/0", bif.len_err, bif.byte_ready);
    end
  endtask

  task automatic test_gaps_and_ignored_start();
    int w0;
    w0 = writes;
    do_start(32'h0000_0200, 16'd3);
    checks++;
    if (bif.len_err !== 1'b0) begin
      errors++;
      $display("FAIL len_err_clear got %b required 0", bif.len_err);
    end
    send_word(32'hA1B2_C3D4, 1'b1);
    send_word(32'h0F1E_2D3C, 1'b1);
    // Start held across the WRITE cycle and the following LOAD cycle.
    bif.byte_valid = 1'b0;
    bif.start      = 1'b1;
    bif.base_addr  = 32'h0000_1000;
    bif.num_words  = 16'd7;
    repeat (2) @(negedge clk);
    bif.start = 1'b0;
    send_word(32'h5566_7788, 1'b1);
    wait_done("gaps");
    checks++;
    if (writes - w0 !== 3 || bif.mem_addr !== 32'h0000_020C) begin
      errors++;
      $display("FAIL gaps_final got writes=%0d addr=%h required 3/0000020c", writes - w0, bif.mem_addr);
    end
  endtask

  task automatic test_reset_midword();
    int w0;
    w0 = writes;
    do_start(32'h0000_0080, 16'd1);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    @(negedge clk);
    bif.byte_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bif.byte_ready, bif.mem_we, bif.cpu_hold, bif.done, bif.len_err} !== 5'b0
        || bif.mem_addr !== 32'h0 || bif.mem_din !== 32'h0) begin
      errors++;
      $display("FAIL async_reset got ctrl=%b addr=%h data=%h required 00000/0/0",
               {bif.byte_ready, bif.mem_we, bif.cpu_hold, bif.done, bif.len_err}, bif.mem_addr, bif.mem_din);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    do_start(32'h0000_0080, 16'd1);
    send_word(32'h1122_3344, 1'b0);
    wait_done("reload");
    checks++;
    if (writes - w0 !== 1 || bif.mem_din !== 32'h1122_3344) begin
      errors++;
      $display("FAIL reload_word got writes=%0d data=%h required 1/11223344", writes - w0, bif.mem_din);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_align_wrap();
    test_zero_words();
    test_over_length();
    test_gaps_and_ignored_start();
    test_reset_midword();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
